// File: rtl/axi_ram_pkg.sv
// Shared AXI definitions for the axi_ram slave.
// Response codes and response type.
package axi_ram_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  localparam int STRB_W = 4;

endpackage

// File: rtl/axi_ram_bram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// Read-before-write on a same-address collision. Ports: clk, rst_n, we/waddr/be/wdata, re/raddr/rdata.
module axi_ram_bram
  import axi_ram_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter int    IW        = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [STRB_W-1:0] be,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [IW-1:0]     raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Non-blocking read of mem sees the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_ram.sv
// AXI4-Lite slave backed by word RAM; one outstanding op per channel.
// Ports: aclk, aresetn, AW/W/B and AR/R channels (axi.slave signal set).
module axi_ram
  import axi_ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
  parameter string                 INIT_FILE  = ""
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN =
    {1'b0, ADDR_WIDTH'(DEPTH)} << 2;

  typedef enum logic [1:0] {
    W_IDLE, W_ADDR, W_DATA, W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE, R_RESP
  } rstate_t;

  function automatic logic in_range(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE;
    return (a >= BASE) && ({1'b0, off} < SPAN);
  endfunction

  function automatic logic [IW-1:0] idx_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE;
    return off[IW+1:2];
  endfunction

  function automatic resp_t resp_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    return in_range(a) ? RESP_OKAY : RESP_DECERR;
  endfunction

  wstate_t                 wst;
  rstate_t                 rst;
  logic [ADDR_WIDTH-1:0]   aw_q;
  logic [DATA_WIDTH-1:0]   wd_q;
  logic [DATA_WIDTH/8-1:0] ws_q;
  logic                    rd_err;
  logic [31:0]             ram_q;

  logic                    aw_fire;
  logic                    w_fire;
  logic                    ar_fire;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [DATA_WIDTH-1:0]   c_data;
  logic [DATA_WIDTH/8-1:0] c_strb;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign ar_fire = arvalid && arready;

  // Pick the write beat from live inputs or the latched half.
  always_comb begin
    commit = 1'b0;
    c_addr = awaddr;
    c_data = wdata;
    c_strb = wstrb;
    unique case (wst)
      W_IDLE: commit = aw_fire && w_fire;
      W_ADDR: begin
        commit = w_fire;
        c_addr = aw_q;
      end
      W_DATA: begin
        commit = aw_fire;
        c_data = wd_q;
        c_strb = ws_q;
      end
      default: commit = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wst     <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      aw_q    <= '0;
      wd_q    <= '0;
      ws_q    <= '0;
    end else begin
      unique case (wst)
        W_IDLE: begin
          awready <= 1'b1;
          wready  <= 1'b1;
          if (aw_fire && w_fire) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= resp_of(c_addr);
            wst     <= W_RESP;
          end else if (aw_fire) begin
            aw_q    <= awaddr;
            awready <= 1'b0;
            wst     <= W_ADDR;
          end else if (w_fire) begin
            wd_q   <= wdata;
            ws_q   <= wstrb;
            wready <= 1'b0;
            wst    <= W_DATA;
          end
        end
        W_ADDR: begin
          if (w_fire) begin
            wready <= 1'b0;
            bvalid <= 1'b1;
            bresp  <= resp_of(c_addr);
            wst    <= W_RESP;
          end
        end
        W_DATA: begin
          if (aw_fire) begin
            awready <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= resp_of(c_addr);
            wst     <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            wst     <= W_IDLE;
          end
        end
        default: wst <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst     <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rresp   <= RESP_OKAY;
      rd_err  <= 1'b0;
    end else begin
      unique case (rst)
        R_IDLE: begin
          arready <= 1'b1;
          if (ar_fire) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rresp   <= resp_of(araddr);
            rd_err  <= !in_range(araddr);
            rst     <= R_RESP;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            rst     <= R_IDLE;
          end
        end
        default: rst <= R_IDLE;
      endcase
    end
  end

  // ram_q only reloads on an AR handshake, so it is stable in R_RESP.
  assign rdata = rd_err ? '0 : ram_q;

  axi_ram_bram #(
    .DEPTH    (DEPTH),
    .IW       (IW),
    .INIT_FILE(INIT_FILE)
  ) u_bram (
    .clk  (aclk),
    .rst_n(aresetn),
    .we   (commit && in_range(c_addr)),
    .waddr(idx_of(c_addr)),
    .be   (c_strb),
    .wdata(c_data),
    .re   (ar_fire),
    .raddr(idx_of(araddr)),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_axi_ram.sv
// Directed + randomized bench for axi_ram.
// Word-array reference model with byte merge on writes.
module tb_axi_ram;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_4000;
  localparam logic [31:0] SPAN  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  axi_ram #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DEPTH     (DEPTH),
    .BASE      (BASE),
    .INIT_FILE ("")
  ) dut (
    .aclk   (clk),
    .aresetn(aresetn),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .rready (rready)
  );

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] model [64];

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + SPAN);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_rng(a) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return in_rng(a) ? model[int'((a - BASE) >> 2)] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] ed,
                          input logic [1:0] er, input int rhold);
    int n;
    n = 0;
    araddr  = a;
    arvalid = 1'b1;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid", 32'(rvalid), 32'd1);
    chk("rdata", rdata, ed);
    chk("rresp", 32'(rresp), 32'(er));
    for (int i = 0; i < rhold; i++) begin
      @(negedge clk);
      chk("rdata_hold", rdata, ed);
      chk("rvalid_hold", 32'(rvalid), 32'd1);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rvalid_clr", 32'(rvalid), 32'd0);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int mode,
                           input int gap, input int hold);
    int n;
    logic [1:0] er;
    er = exp_resp(a);
    n  = 0;
    if (mode == 0) begin
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      while (!(awready && wready) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("aw_w_wait", 32'(n < 20), 32'd1);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end else if (mode == 1) begin
      wdata  = d;
      wstrb  = s;
      wvalid = 1'b1;
      while (!wready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("w_wait", 32'(n < 20), 32'd1);
      @(negedge clk);
      wvalid = 1'b0;
      for (int i = 0; i < gap; i++) begin
        chk("wready_low", 32'(wready), 32'd0);
        chk("bvalid_early", 32'(bvalid), 32'd0);
        @(negedge clk);
      end
      awaddr  = a;
      awvalid = 1'b1;
      n = 0;
      while (!awready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("aw_wait", 32'(n < 20), 32'd1);
      @(negedge clk);
      awvalid = 1'b0;
    end else begin
      awaddr  = a;
      awvalid = 1'b1;
      while (!awready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("aw_wait", 32'(n < 20), 32'd1);
      @(negedge clk);
      awvalid = 1'b0;
      for (int i = 0; i < gap; i++) begin
        chk("awready_low", 32'(awready), 32'd0);
        chk("bvalid_early", 32'(bvalid), 32'd0);
        @(negedge clk);
      end
      wdata  = d;
      wstrb  = s;
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("w_wait", 32'(n < 20), 32'd1);
      @(negedge clk);
      wvalid = 1'b0;
    end
    chk("bvalid", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), 32'(er));
    if (hold > 0) begin
      axi_read(BASE + 32'h4, model[1], 2'b00, 0);
      for (int i = 0; i < hold; i++) begin
        chk("bvalid_hold", 32'(bvalid), 32'd1);
        chk("bresp_hold", 32'(bresp), 32'(er));
        chk("awready_hold", 32'(awready), 32'd0);
        @(negedge clk);
      end
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_clr", 32'(bvalid), 32'd0);
    if (in_rng(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[int'((a - BASE) >> 2)][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  initial begin
    logic [31:0] old;
    logic [31:0] nw;
    logic [31:0] a;

    aresetn = 1'b0;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'({awready, wready, arready, bvalid, rvalid}), 32'd0);
    chk("rst_resp", 32'({bresp, rresp}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'({awready, wready, arready}), 32'b111);

    for (int i = 0; i < 64; i++) begin
      axi_write(BASE + 32'(4 * i), $urandom, 4'hF,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
    end

    axi_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    axi_read(BASE + 32'h10, 32'hDEAD_BEEF, 2'b00, 0);
    axi_write(BASE + 32'h20, 32'h1122_3344, 4'hF, 1, 3, 0);
    axi_read(BASE + 32'h20, 32'h1122_3344, 2'b00, 0);
    axi_write(BASE + 32'h24, 32'h1122_3344, 4'hF, 2, 3, 0);
    axi_read(BASE + 32'h24, 32'h1122_3344, 2'b00, 0);
    axi_write(BASE + 32'h10, 32'h0000_00AA, 4'b0001, 0, 0, 0);
    axi_read(BASE + 32'h10, 32'hDEAD_BEAA, 2'b00, 2);
    axi_write(BASE + 32'h14, 32'hCAFE_F00D, 4'h0, 0, 0, 0);
    axi_read(BASE + 32'h14, exp_rd(BASE + 32'h14), 2'b00, 0);

    axi_read(BASE + SPAN, 32'h0, 2'b11, 1);
    axi_read(BASE - 32'h4, 32'h0, 2'b11, 0);
    old = model[0];
    axi_write(BASE + SPAN, 32'h1234_5678, 4'hF, 0, 0, 0);
    axi_read(BASE, old, 2'b00, 0);
    axi_write(BASE - 32'h4, 32'h1234_5678, 4'hF, 1, 1, 0);

    axi_write(BASE + 32'h30, 32'hA5A5_5A5A, 4'hF, 0, 0, 5);
    axi_read(BASE + 32'h30, 32'hA5A5_5A5A, 2'b00, 0);

    old = model[16];
    nw  = ~old;
    chk("rdy_pre_rw", 32'({awready, wready, arready}), 32'b111);
    awaddr  = BASE + 32'h40;
    wdata   = nw;
    wstrb   = 4'hF;
    araddr  = BASE + 32'h40;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    chk("rw_rvalid", 32'(rvalid), 32'd1);
    chk("rw_old_data", rdata, old);
    chk("rw_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    rready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    rready = 1'b0;
    model[16] = nw;
    axi_read(BASE + 32'h40, nw, 2'b00, 0);

    old     = model[32];
    awaddr  = BASE + 32'h80;
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("w_addr_rdy", 32'({awready, wready}), 32'b01);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_ctrl", 32'({awready, wready, arready, bvalid, rvalid}), 32'd0);
    chk("mid_rst_resp", 32'({bresp, rresp}), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    chk("rdy_after_mid_rst", 32'({awready, wready, arready}), 32'b111);
    chk("no_b_after_rst", 32'(bvalid), 32'd0);
    axi_read(BASE + 32'h80, old, 2'b00, 0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0)
        a = BASE + SPAN + 32'(4 * $urandom_range(0, 15));
      else
        a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
      axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? 2 : 0);
      if ($urandom_range(0, 9) == 0)
        a = BASE - 32'(4 * $urandom_range(1, 8));
      else
        a = BASE + 32'(4 * $urandom_range(0, 63));
      axi_read(a, exp_rd(a), exp_resp(a), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
